// File: rtl/jtframe_mon_pkg.sv
// Shared constants and types for the frame monitor: CRC-16-CCITT parameters,
// pixel width and the dump-window state encoding.
package jtframe_mon_pkg;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam int          PXLW     = 24;

  typedef enum logic [1:0] {WAIT, ACTIVE, DONE} win_e;
endpackage

// File: rtl/jtframe_crc16.sv
// Registered CRC-16-CCITT accumulator folding one 24-bit pixel per enabled cycle.
// seed restarts from CRC_INIT; seed together with en folds din into the fresh seed.
module jtframe_crc16
  import jtframe_mon_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            seed,
  input  logic            en,
  input  logic [PXLW-1:0] din,
  output logic [15:0]     crc
);
  logic [15:0] base, nxt;

  // MSB-first bit-serial update unrolled over the whole pixel
  always_comb begin
    base = seed ? CRC_INIT : crc;
    nxt  = base;
    for (int i = PXLW-1; i >= 0; i--)
      nxt = {nxt[14:0], 1'b0} ^ ({16{nxt[15] ^ din[i]}} & CRC_POLY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       crc <= CRC_INIT;
    else if (en)   crc <= nxt;
    else if (seed) crc <= CRC_INIT;
  end
endmodule

// File: rtl/jtframe_frame_mon.sv
// Frame monitor: counts vs falling edges, drives the dump window and, when
// JTFRAME_FRAME_SIG_EN is defined, publishes a per-frame CRC-16 video signature.
module jtframe_frame_mon
  import jtframe_mon_pkg::*;
#(
  parameter int          CW          = 32,
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned STOP_FRAME  = 0
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            pxl_cen,
  input  logic            vs,
  input  logic            lhbl,
  input  logic            lvbl,
  input  logic [PXLW-1:0] rgb,
  output logic [CW-1:0]   frame_cnt,
  output logic            frame_pulse,
  output logic            dump_en,
  output logic [15:0]     sig,
  output logic            sig_valid,
  input  logic            sig_ack,
  output logic            sig_ovr
);
  localparam win_e ST_RST = (START_FRAME == 0) ? ACTIVE : WAIT;

  logic          vs_l, boundary;
  logic [CW-1:0] cnt_nxt;
  win_e          st, st_nxt;

  assign boundary = vs_l & ~vs;
  assign cnt_nxt  = frame_cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_l        <= 1'b0;
      frame_cnt   <= '0;
      frame_pulse <= 1'b0;
      st          <= ST_RST;
      dump_en     <= (ST_RST == ACTIVE);
    end else begin
      vs_l        <= vs;
      frame_pulse <= boundary;
      if (boundary) frame_cnt <= cnt_nxt;
      st          <= st_nxt;
      dump_en     <= (st_nxt == ACTIVE);
    end
  end

  // DONE never leaves, so a counter wrap cannot re-open the window
  always_comb begin
    st_nxt = st;
    if (boundary) begin
      case (st)
        WAIT:    if (cnt_nxt == CW'(START_FRAME)) st_nxt = ACTIVE;
        ACTIVE:  if (STOP_FRAME != 0 && cnt_nxt == CW'(STOP_FRAME)) st_nxt = DONE;
        default: st_nxt = st;
      endcase
    end
  end

`ifdef JTFRAME_FRAME_SIG_EN
  logic [15:0] crc;
  logic        primed, pix, publish;

  assign pix     = pxl_cen & lhbl & lvbl;
  // the first boundary after reset closes a partial frame
  assign publish = boundary & primed;

  jtframe_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .seed (boundary),
    .en   (pix),
    .din  (rgb),
    .crc  (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed    <= 1'b0;
      sig       <= '0;
      sig_valid <= 1'b0;
      sig_ovr   <= 1'b0;
    end else begin
      if (boundary) primed <= 1'b1;
      if (publish) begin
        sig       <= crc;
        sig_valid <= 1'b1;
        if (sig_valid && !sig_ack) sig_ovr <= 1'b1;
      end else if (sig_ack) begin
        sig_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_sig;
  assign unused_sig = ^{pxl_cen, lhbl, lvbl, rgb, sig_ack};
  assign sig        = '0;
  assign sig_valid  = 1'b0;
  assign sig_ovr    = 1'b0;
`endif
endmodule

// File: tb/tb_jtframe_frame_mon.sv
// Scoreboard bench for jtframe_frame_mon: three parameterizations share the
// same video stimulus; expected per-boundary results are queued and popped on frame_pulse.
module tb_jtframe_frame_mon;
`ifdef JTFRAME_FRAME_SIG_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic        clk, rst, pxl_cen, vs, lhbl, lvbl, sig_ack;
  logic [23:0] rgb;

  logic [31:0] f0_cnt;
  logic        f0_pulse, f0_den, f0_valid, f0_ovr;
  logic [15:0] f0_sig;
  logic [31:0] f1_cnt;
  logic        f1_pulse, f1_den;
  logic [3:0]  f2_cnt;
  logic        f2_pulse, f2_den;
  logic [15:0] unused_sig1, unused_sig2;
  logic        unused_v1, unused_v2, unused_o1, unused_o2;

  jtframe_frame_mon #(.CW(32), .START_FRAME(0), .STOP_FRAME(0)) dut0 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .vs(vs), .lhbl(lhbl), .lvbl(lvbl), .rgb(rgb),
    .frame_cnt(f0_cnt), .frame_pulse(f0_pulse), .dump_en(f0_den),
    .sig(f0_sig), .sig_valid(f0_valid), .sig_ack(sig_ack), .sig_ovr(f0_ovr));

  jtframe_frame_mon #(.CW(32), .START_FRAME(3), .STOP_FRAME(6)) dut1 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .vs(vs), .lhbl(lhbl), .lvbl(lvbl), .rgb(rgb),
    .frame_cnt(f1_cnt), .frame_pulse(f1_pulse), .dump_en(f1_den),
    .sig(unused_sig1), .sig_valid(unused_v1), .sig_ack(sig_ack), .sig_ovr(unused_o1));

  jtframe_frame_mon #(.CW(4), .START_FRAME(2), .STOP_FRAME(5)) dut2 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .vs(vs), .lhbl(lhbl), .lvbl(lvbl), .rgb(rgb),
    .frame_cnt(f2_cnt), .frame_pulse(f2_pulse), .dump_en(f2_den),
    .sig(unused_sig2), .sig_valid(unused_v2), .sig_ack(sig_ack), .sig_ovr(unused_o2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic [3:0]  cnt2;
    bit          d0, d1, d2;
    logic [15:0] sig;
    bit          vld, ovr;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;

  // reference model state
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt2;
  int          st0, st1, st2;   // 0 wait, 1 active, 2 done
  bit          primed, e_valid, e_ovr;
  logic [15:0] acc, e_sig;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_byte(logic [15:0] c, logic [7:0] b);
    c ^= {b, 8'h00};
    for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic logic [15:0] crc_pix(logic [15:0] c, logic [23:0] p);
    return crc_byte(crc_byte(crc_byte(c, p[23:16]), p[15:8]), p[7:0]);
  endfunction

  function automatic int win_nx(int st, int unsigned c, int unsigned start, int unsigned stop);
    if (st == 0 && c == start) return 1;
    if (st == 1 && stop != 0 && c == stop) return 2;
    return st;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_cnt2 = 0; st0 = 1; st1 = 0; st2 = 0;
    primed = 0; e_valid = 0; e_ovr = 0; acc = 16'hFFFF; e_sig = 16'h0;
  endtask

  task automatic do_frame(input int npix, input bit rnd, input bit edge_pix, input bit edge_ack);
    logic [23:0] p;
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      p = rnd ? 24'($urandom) : 24'h0;
      @(posedge clk); #1; pxl_cen = 1; lhbl = 1; lvbl = 1; rgb = p;
      acc = crc_pix(acc, p);
      @(posedge clk); #1; pxl_cen = 0; rgb = 24'hA5A5A5;
      @(posedge clk); #1; pxl_cen = 1; lhbl = 0;
      @(posedge clk); #1; pxl_cen = 0; lhbl = 1;
    end
    @(posedge clk); #1; lvbl = 0; vs = 1;
    @(posedge clk); #1;
    p = 24'($urandom);
    @(posedge clk); #1; vs = 0;
    if (edge_pix) begin pxl_cen = 1; lvbl = 1; rgb = p; end
    if (edge_ack) sig_ack = 1;
    m_cnt++; m_cnt2++;
    st0 = win_nx(st0, m_cnt, 0, 0);
    st1 = win_nx(st1, m_cnt, 3, 6);
    st2 = win_nx(st2, 32'(m_cnt2), 2, 5);
    if (primed) begin
      if (e_valid && !edge_ack) e_ovr = 1;
      e_sig = acc; e_valid = 1;
    end else if (edge_ack) e_valid = 0;
    primed = 1;
    acc = edge_pix ? crc_pix(16'hFFFF, p) : 16'hFFFF;
    e.cnt = m_cnt; e.cnt2 = m_cnt2;
    e.d0 = (st0 == 1); e.d1 = (st1 == 1); e.d2 = (st2 == 1);
    e.sig = SIG_EN ? e_sig : 16'h0;
    e.vld = SIG_EN & e_valid;
    e.ovr = SIG_EN & e_ovr;
    q.push_back(e);
    @(negedge clk); chk("pulse_early", f0_pulse, 0);
    @(posedge clk); #1; pxl_cen = 0; sig_ack = 0; lvbl = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic ack_sig();
    @(posedge clk); #1; sig_ack = 1;
    @(posedge clk); #1; sig_ack = 0;
    e_valid = 0;
    @(negedge clk);
    chk("ack_clr", f0_valid, 0);
    chk("ack_sig", f0_sig, SIG_EN ? e_sig : 16'h0);
  endtask

  // scoreboard drain
  always @(negedge clk) begin
    if (!rst && f0_pulse) begin
      if (q.size() == 0) chk("spurious_pulse", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("cnt0", f0_cnt, e.cnt);
        chk("den0", f0_den, e.d0);
        chk("cnt1", f1_cnt, e.cnt);
        chk("den1", f1_den, e.d1);
        chk("pulse12", {f1_pulse, f2_pulse}, 2'b11);
        chk("cnt2", f2_cnt, e.cnt2);
        chk("den2", f2_den, e.d2);
        chk("sig", f0_sig, e.sig);
        chk("sig_valid", f0_valid, e.vld);
        chk("sig_ovr", f0_ovr, e.ovr);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt0"}, f0_cnt, 0);
    chk({tag, "_cnt2"}, f2_cnt, 0);
    chk({tag, "_pulse"}, {f0_pulse, f1_pulse, f2_pulse}, 0);
    chk({tag, "_den"}, {f0_den, f1_den, f2_den}, 3'b100);
    chk({tag, "_sig"}, f0_sig, 0);
    chk({tag, "_valid"}, f0_valid, 0);
    chk({tag, "_ovr"}, f0_ovr, 0);
  endtask

  initial begin
    rst = 1; pxl_cen = 0; vs = 0; lhbl = 1; lvbl = 0; rgb = 0; sig_ack = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); chk_reset_vals("rst");
    @(posedge clk); #1; rst = 0;

    for (int i = 1; i <= 20; i++) begin
      do_frame((i <= 5) ? 1 : $urandom_range(1, 4), i > 5, i == 6 || i == 12, i == 5);
      if (i != 4 && i != 7) ack_sig();
    end

    // asynchronous reset in the middle of active video
    @(posedge clk); #1; pxl_cen = 1; lhbl = 1; lvbl = 1; rgb = 24'h123456;
    #2; rst = 1;
    #1; chk_reset_vals("async");
    @(posedge clk); #1; rst = 0; pxl_cen = 0; lvbl = 0;
    model_reset();
    do_frame(2, 1, 0, 0);
    do_frame(3, 1, 0, 0);
    ack_sig();

    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jtframe_frame_mon.md
Name: jtframe_frame_mon

Overview:
- Synthesizable frame monitor on the game video output. It is the producer side of the simulation dump trigger.
- Counts frames on the falling edge of vertical sync and publishes the frame count.
- Generates a dump/capture window between two frame numbers.
- Computes a per-frame CRC-16 video signature. Regression benches and on-board debug compare this signature across runs.

Parameters:
- CW, 32, frame counter width.
- START_FRAME, 0, frame number that opens the window. 0 means open from reset.
- STOP_FRAME, 0, frame number that closes the window. 0 means never close. Must be greater than START_FRAME when non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pxl_cen  in  1  pixel clock enable
- vs  in  1  vertical sync; frame boundary is its falling edge
- lhbl  in  1  horizontal blank, active low
- lvbl  in  1  vertical blank, active low
- rgb  in  24  pixel colour, {r,g,b}, 8 bits each
- frame_cnt  out  CW  completed-frame count
- frame_pulse  out  1  one-cycle strobe on each boundary
- dump_en  out  1  capture window active
- sig  out  16  latched CRC of the last complete frame
- sig_valid  out  1  sig holds an unconsumed value
- sig_ack  in  1  consumer accepts sig
- sig_ovr  out  1  sticky overrun flag

Behaviour:
- Reset values: frame_cnt=0, frame_pulse=0, dump_en=(START_FRAME==0), sig=0, sig_valid=0, sig_ovr=0, CRC accumulator=16'hFFFF.
- Edge detect: vs is registered once (vs_l). A boundary is the cycle where vs_l=1 and vs=0; pxl_cen is not required.
  - frame_pulse=1 and frame_cnt+1 both appear on the cycle after the boundary, i.e. 1-cycle latency.
  - frame_cnt wraps from all-ones to 0 silently.
- Window FSM, states WAIT/ACTIVE/DONE:
  - Reset state is ACTIVE if START_FRAME==0, else WAIT.
  - WAIT->ACTIVE when the incremented count equals START_FRAME.
  - ACTIVE->DONE when the incremented count equals STOP_FRAME and STOP_FRAME!=0.
  - DONE is terminal until reset; counter wrap does not re-arm the window.
  - dump_en=1 only in ACTIVE and is registered; it changes on the same cycle as frame_pulse.
- CRC:
  - CRC-16-CCITT, polynomial 16'h1021, init 16'hFFFF, MSB-first.
  - Each pixel feeds 24 bits, r[7] first, b[0] last.
  - Updated on cycles with pxl_cen & lhbl & lvbl.
- Boundary cycle handling:
  - If the boundary coincides with a qualifying pixel, the pixel is folded into the new frame: seed 16'hFFFF, then the pixel.
  - The old accumulator is latched into sig.
- First boundary after reset covers a partial frame: the accumulator is reseeded but nothing is published. Publishing starts from the second boundary.
- Publish/handshake:
  - On publish, sig updates and sig_valid=1 next cycle.
  - sig_ack while sig_valid=1 and no publish: sig_valid=0 next cycle.
  - Publish together with ack: sig_valid stays 1, sig takes the new value, no overrun.
  - Publish while sig_valid=1 and no ack: sig is overwritten and sig_ovr is set. sig_ovr stays set until reset.
  - sig_ack while sig_valid=0 is ignored.
- Reset asserted mid-frame clears everything asynchronously. The first boundary after reset release is again treated as partial.

Optional Feature:
- Macro JTFRAME_FRAME_SIG_EN.
- Defined: CRC engine, sig, sig_valid, sig_ovr and the handshake are present as above.
- Undefined: no CRC logic is synthesized.
  - sig=0, sig_valid=0, sig_ovr=0 constantly; sig_ack, rgb, lhbl and lvbl are ignored.
  - Frame counter, frame_pulse and dump_en are unchanged.

Decomposition:
- Package jtframe_mon_pkg holds:
  - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF;
  - the window state enum {WAIT, ACTIVE, DONE};
  - the pixel width constant PXLW=24.
- Sub-module jtframe_crc16 contains the registered accumulator.
  - Inputs: clk, rst, seed (reseed strobe), en, din[23:0]. Output: crc[15:0].
  - Internally an unrolled 24-bit combinational step.
  - Instantiated only under JTFRAME_FRAME_SIG_EN.

Test Plan:
- Reset, then five vs falling edges, START_FRAME=0 -> frame_cnt=5; five one-cycle frame_pulses, each one cycle after its edge; dump_en=1 throughout.
- START_FRAME=3, STOP_FRAME=6, 10 frames -> dump_en rises with frame_pulse at count 3, falls at count 6, stays 0 through count 10.
- CW=4, 20 frames -> frame_cnt goes 15→0→4. With START_FRAME=2, STOP_FRAME=5, dump_en does not reassert after the wrap.
- Signature: single active pixel rgb=24'h000000 per frame; ack each -> no publish at the first boundary; afterwards sig matches the software CRC-16-CCITT over 3 zero bytes; sig_valid clears one cycle after sig_ack.
- Two boundaries with no ack -> sig_ovr=1 and sig equals the second frame's CRC. Publish in the same cycle as ack -> sig_valid stays 1 and sig_ovr unchanged.
- Assert rst mid-frame during active pixels -> all outputs at reset values immediately; first post-reset boundary publishes nothing; second boundary publishes a full-frame CRC.
